// File: rtl/freq_gate_counter.sv
// freq_gate_counter: front end of the digital frequency meter.
// Synchronises sig_in, counts its rising edges in BCD over a window of
// GATE_CYCLES clocks, then pulses latch_en for one cycle so the downstream
// latch stage can capture q0..q7. One measurement runs per GATE_CYCLES+2
// clocks: CLEAR (1) -> GATE (GATE_CYCLES) -> LATCH (1).
// Optional build macro FREQ_OVF_EN adds the ovf port and saturates the count
// at all-9. Without it the count wraps modulo 10^OVF_DIGITS.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int OVF_DIGITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] q4,
  output logic [3:0] q5,
  output logic [3:0] q6,
  output logic [3:0] q7,
`ifdef FREQ_OVF_EN
  output logic       ovf,
`endif
  output logic       latch_en
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          s1, s2, s3;
  logic          sig_edge;
  logic [3:0]    dig     [8];
  logic [3:0]    dig_inc [8];
`ifdef FREQ_OVF_EN
  logic          all_nine;
`endif

  // Two-flop synchroniser for the asynchronous input plus one flop for edge detect.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift chain work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A level that is already high at reset release still shows up as one edge,
  // because s3 starts at 0.
  assign sig_edge = s2 & ~s3;

  // Gate window sequencer; latch_en is registered so it is high exactly during LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      timer    <= '0;
      latch_en <= 1'b0;
    end else begin
      latch_en <= 1'b0;
      case (state)
        ST_CLEAR: begin
          timer <= '0;
          state <= ST_GATE;
        end
        ST_GATE: begin
          if (timer == TIMER_LAST) begin
            state    <= ST_LATCH;
            latch_en <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_LATCH: state <= ST_CLEAR;
        default:  state <= ST_CLEAR;
      endcase
    end
  end

  // Ripple BCD incrementer over the active digits; inactive digits pass through.
  always_comb begin
    logic carry;
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dig_inc[i] = dig[i];
      if (i < OVF_DIGITS) begin
        // NOTE: blocking assignments here on purpose: carry must ripple from
        // digit i to digit i+1 within the same evaluation.
        if (carry) dig_inc[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
        carry = carry & (dig[i] == 4'd9);
      end
    end
`ifdef FREQ_OVF_EN
    // Carry out of the top active digit means all active digits read 9.
    all_nine = carry;
`endif
  end

  // Count register: cleared in CLEAR, bumped on each edge during GATE, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the digit array is eight small registers, not a RAM, so it is
      // reset like any other flop; the outputs must read zero during reset.
      for (int i = 0; i < 8; i++) dig[i] <= 4'd0;
`ifdef FREQ_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == ST_CLEAR) begin
      for (int i = 0; i < 8; i++) dig[i] <= 4'd0;
`ifdef FREQ_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == ST_GATE && sig_edge) begin
`ifdef FREQ_OVF_EN
      // Saturate at all-9 and flag the overflow until the next CLEAR.
      if (all_nine) begin
        ovf <= 1'b1;
      end else begin
        for (int i = 0; i < 8; i++) dig[i] <= dig_inc[i];
      end
`else
      // All-9 wraps to all-0 through the carry chain; counting continues.
      for (int i = 0; i < 8; i++) dig[i] <= dig_inc[i];
`endif
    end
  end

  assign q0 = dig[0];
  assign q1 = dig[1];
  assign q2 = dig[2];
  assign q3 = dig[3];
  assign q4 = dig[4];
  assign q5 = dig[5];
  assign q6 = dig[6];
  assign q7 = dig[7];

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Front end of the digital frequency meter, directly upstream of the 8-digit result latch stage.
- Synchronises the signal under test and counts its rising edges in BCD over a fixed gate window timed from the system clock.
- Emits a one-cycle latch_en pulse at the end of each window so the latch stage captures q0..q7.
- Runs continuously, with one measurement per gate period.

Parameters:
- GATE_CYCLES, 50_000_000: gate window length in clk cycles (1 s at 50 MHz).
- OVF_DIGITS, 8: number of active BCD digits, range 1..8. Digits at or above OVF_DIGITS are held at 0. Sets the saturation/overflow point.

Ports:
- clk  input  1  system clock. All logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal under test. Asynchronous to clk; frequency must not exceed clk/2.
- q0..q7  output  4 each  BCD count digits. q0 is the least significant. Valid while latch_en=1.
- latch_en  output  1  one-cycle pulse when q0..q7 hold the final count of a window.
- ovf  output  1  (FREQ_OVF_EN only) count exceeded its range in this window. Valid with latch_en.

Behaviour:
- Reset (rst_n=0):
  - Async clear of all outputs: q0..q7=0, latch_en=0, ovf=0.
  - Sync chain and edge-detect registers reset to 0.
  - Gate timer reset to 0.
  - FSM forced to CLEAR.
  - Reset may be asserted in any state. The measurement in progress is discarded.
- Input path:
  - 2-flop synchroniser, then a third flop for edge detect.
  - edge = s2 & ~s3.
  - Latency from sig_in rising to edge pulse: 2-3 clk.
  - sig_in already high at reset release counts as one edge.
- FSM states:
  - CLEAR, 1 cycle: digits cleared to 0, ovf cleared, gate timer cleared. Next state GATE.
  - GATE, exactly GATE_CYCLES cycles: each cycle with edge=1 increments the BCD count by 1. Timer counts 0..GATE_CYCLES-1. On the cycle where timer = GATE_CYCLES-1 (an edge on that cycle still counts), next state is LATCH.
  - LATCH, 1 cycle: latch_en=1. Digits frozen. Next state CLEAR.
- Timing:
  - Full period is GATE_CYCLES+2 cycles.
  - After reset release: cycle 0 CLEAR, cycles 1..GATE_CYCLES GATE, cycle GATE_CYCLES+1 LATCH.
  - latch_en is registered; it is high exactly during the LATCH cycle.
- BCD increment:
  - Digit i increments when all lower active digits equal 9.
  - A digit at 9 wraps to 0 and carries.
  - Digits never hold values above 9.
- Range limit: max count is 10^OVF_DIGITS - 1 (all active digits 9). An edge at the max count is the overflow event.
- Edges outside GATE (CLEAR, LATCH) are ignored.
- q0..q7 change only in CLEAR and GATE. The downstream latch samples them during latch_en.

Optional Feature:
- Macro: FREQ_OVF_EN.
- Defined:
  - ovf port present.
  - On an overflow event, digits saturate at all-9 and ovf=1 (sticky until the next CLEAR).
- Undefined:
  - No ovf port.
  - On an overflow event, the active digits wrap to all-0 and counting continues. The count is modulo 10^OVF_DIGITS.

Test Plan:
- GATE_CYCLES=100, sig_in period 4 clk (2 high/2 low), steady state -> at each latch_en pulse: q1=2, q0=5, others 0. latch_en pulses are spaced exactly 102 cycles apart.
- GATE_CYCLES=100, sig_in held low -> every latch_en pulse shows q0..q7=0 and ovf=0. Pulse spacing is 102 cycles.
- GATE_CYCLES=2000, sig_in period 2 clk -> count 1000: q3=1, q2=q1=q0=0. Checks the carry chain across three digits.
- GATE_CYCLES=99, sig_in period 3 clk (1 high/2 low) -> q1=3, q0=3.
- OVF_DIGITS=2, GATE_CYCLES=300, sig_in period 2 clk (150 edges):
  - With FREQ_OVF_EN: q1=9, q0=9, ovf=1. ovf returns to 0 in the following CLEAR.
  - Without FREQ_OVF_EN: q1=5, q0=0 (150 mod 100). q2..q7=0.
- rst_n pulled low for 3 cycles mid-GATE with count nonzero -> q0..q7=0 and latch_en=0 immediately. After release: CLEAR, then a full GATE_CYCLES window, with the first latch_en at cycle GATE_CYCLES+1 and no partial result emitted.
